cache_mem_responder: RTL

- Main-memory side of the cache miss/write interface; the responder that cacheBlock talks to on a miss or a write-through.
- Accepts one request at a time through a valid/ready handshake.
- Read requests: after a fixed latency, returns a whole cache block, one word per cycle, critical word first.
- Write requests: after the same latency, commits one word to the backing array and pulses an acknowledge.

---
 rtl/cache_mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: main-memory side of the cache miss / write-through
// interface. It accepts one request at a time. A read returns a whole block,
// critical word first, after LATENCY cycles. A write commits one word after
// LATENCY cycles and pulses wr_ack.
module cache_mem_responder #(
    parameter int LATENCY     = 4,
    parameter int BLOCK_WORDS = 4,
    parameter int MEM_AW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic [15:0] rd_addr,
    output logic        rd_last,
    output logic        wr_ack
);

    localparam int OFFW = $clog2(BLOCK_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_t;

    state_t            state;
    logic [3:0]        latCnt;
    logic [OFFW-1:0]   beatCnt;
    logic              latWrite;
    logic [15:0]       latAddr;
    logic [15:0]       latWdata;

    logic [15:0]       mem [0:(1 << MEM_AW) - 1];

    logic [OFFW-1:0]   beatOff;
    logic [15:0]       beatAddr;
    logic              commit;

    // The beat address keeps the block base and wraps the offset inside the
    // block. OFFW-bit arithmetic gives the modulo for free.
    always_comb begin
        beatOff  = latAddr[OFFW-1:0] + beatCnt;
        beatAddr = {latAddr[15:OFFW], beatOff};
        commit   = (state == WAIT) && latWrite && (latCnt == '0);
    end

    assign req_ready = (state == IDLE);

    // Backing array: no reset. A reset in the commit cycle suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && commit) begin
            mem[latAddr[MEM_AW-1:0]] <= latWdata;
        end
    end

    // Request FSM with registered read-beat and write-ack outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            latCnt   <= '0;
            beatCnt  <= '0;
            latWrite <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
            rd_last  <= 1'b0;
            wr_ack   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
            rd_last  <= 1'b0;
            wr_ack   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        latWrite <= req_write;
                        latAddr  <= req_addr;
                        latWdata <= req_wdata;
                        latCnt   <= 4'(LATENCY - 1);
                        beatCnt  <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (latCnt != '0) begin
                        latCnt <= latCnt - 4'd1;
                    end else if (latWrite) begin
                        wr_ack <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        // The first beat goes out on the edge that leaves WAIT.
                        rd_valid <= 1'b1;
                        rd_addr  <= beatAddr;
                        rd_data  <= mem[beatAddr[MEM_AW-1:0]];
                        beatCnt  <= beatCnt + OFFW'(1);
                        state    <= BURST;
                    end
                end
                BURST: begin
                    rd_valid <= 1'b1;
                    rd_addr  <= beatAddr;
                    rd_data  <= mem[beatAddr[MEM_AW-1:0]];
                    beatCnt  <= beatCnt + OFFW'(1);
                    if (beatCnt == OFFW'(BLOCK_WORDS - 1)) begin
                        rd_last <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
